// File: rtl/depar_seg_splitter.sv
// depar_seg_splitter
//   Head-of-deparser segment steering. Segments popped from the packet FIFO
//   go, in order, to header channel 0..N-1 (one beat per channel per
//   packet), then everything after the last header segment streams to the
//   output FIFO. Packets shorter than N segments are padded: the remaining
//   header channels receive an all-zero filler beat in the same cycle as
//   the packet's last segment. The VLAN ID is captured from segment 0.
//
// Ports
//   clk, aresetn                 clock, async active-low reset
//   pkt_fifo_*                   FWFT packet FIFO head, empty flag, pop strobe
//   hdr_fifo_ready               per-channel not-full
//   hdr_t*, hdr_valid            per-channel beat (channel k at slice k)
//   vlan, vlan_valid             captured VLAN ID and capture strobe
//   output_fifo_*                payload segments after the headers
//   pkt_cnt, short_pkt_cnt       wrapping packet counters
//
// State table
//   ST_HDR   | steering segment seg_idx_q to header channel seg_idx_q
//   ST_FLUSH | all header channels filled; forwarding rest of packet
module depar_seg_splitter #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_HDR_SEGS     = 2,
  parameter int C_VLAN_OFFSET      = 116
) (
  input  logic                                              clk,
  input  logic                                              aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                      pkt_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                     pkt_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                    pkt_fifo_tkeep,
  input  logic                                              pkt_fifo_tlast,
  input  logic                                              pkt_fifo_empty,
  output logic                                              pkt_fifo_rd_en,
  input  logic [C_NUM_HDR_SEGS-1:0]                         hdr_fifo_ready,
  output logic [C_NUM_HDR_SEGS*C_AXIS_DATA_WIDTH-1:0]       hdr_tdata,
  output logic [C_NUM_HDR_SEGS*C_AXIS_TUSER_WIDTH-1:0]      hdr_tuser,
  output logic [C_NUM_HDR_SEGS*C_AXIS_DATA_WIDTH/8-1:0]     hdr_tkeep,
  output logic [C_NUM_HDR_SEGS-1:0]                         hdr_tlast,
  output logic [C_NUM_HDR_SEGS-1:0]                         hdr_valid,
  output logic [11:0]                                       vlan,
  output logic                                              vlan_valid,
  output logic [C_AXIS_DATA_WIDTH-1:0]                      output_fifo_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                     output_fifo_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                    output_fifo_tkeep,
  output logic                                              output_fifo_tlast,
  output logic                                              output_fifo_valid,
  input  logic                                              output_fifo_ready,
  output logic [15:0]                                       pkt_cnt,
  output logic [15:0]                                       short_pkt_cnt
);

  localparam int W  = C_AXIS_DATA_WIDTH;
  localparam int U  = C_AXIS_TUSER_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int N  = C_NUM_HDR_SEGS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_HDR, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   seg_idx_q, seg_idx_d;
  logic [N*W-1:0]  hdr_tdata_q, hdr_tdata_d;
  logic [N*U-1:0]  hdr_tuser_q, hdr_tuser_d;
  logic [N*KW-1:0] hdr_tkeep_q, hdr_tkeep_d;
  logic [N-1:0]    hdr_tlast_q, hdr_tlast_d;
  logic [N-1:0]    hdr_valid_q, hdr_valid_d;
  logic [11:0]     vlan_q, vlan_d;
  logic            vlan_valid_q, vlan_valid_d;
  logic [W-1:0]    out_tdata_q, out_tdata_d;
  logic [U-1:0]    out_tuser_q, out_tuser_d;
  logic [KW-1:0]   out_tkeep_q, out_tkeep_d;
  logic            out_tlast_q, out_tlast_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     short_cnt_q, short_cnt_d;

  // A last segment also fills every later channel, so all of them must
  // have room before it can be popped.
  logic            tail_ready;
  logic            last_hdr;

  always_comb begin
    state_d        = state_q;
    seg_idx_d      = seg_idx_q;
    pkt_fifo_rd_en = 1'b0;
    hdr_tdata_d    = '0;
    hdr_tuser_d    = '0;
    hdr_tkeep_d    = '0;
    hdr_tlast_d    = '0;
    hdr_valid_d    = '0;
    vlan_d         = vlan_q;
    vlan_valid_d   = 1'b0;
    out_tdata_d    = '0;
    out_tuser_d    = '0;
    out_tkeep_d    = '0;
    out_tlast_d    = 1'b0;
    out_valid_d    = 1'b0;
    pkt_cnt_d      = pkt_cnt_q;
    short_cnt_d    = short_cnt_q;
    tail_ready     = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j >= int'(seg_idx_q) && !hdr_fifo_ready[j]) tail_ready = 1'b0;
    end
    last_hdr = (int'(seg_idx_q) == N - 1);

    unique case (state_q)
      ST_HDR: begin
        if (!pkt_fifo_empty &&
            (pkt_fifo_tlast ? tail_ready : hdr_fifo_ready[seg_idx_q])) begin
          pkt_fifo_rd_en = 1'b1;
          for (int j = 0; j < N; j++) begin
            if (j == int'(seg_idx_q)) begin
              hdr_valid_d[j]         = 1'b1;
              hdr_tdata_d[j*W +: W]  = pkt_fifo_tdata;
              hdr_tuser_d[j*U +: U]  = pkt_fifo_tuser;
              hdr_tkeep_d[j*KW +: KW] = pkt_fifo_tkeep;
              hdr_tlast_d[j]         = pkt_fifo_tlast;
            end else if (pkt_fifo_tlast && j > int'(seg_idx_q)) begin
              hdr_valid_d[j] = 1'b1;  // zero filler beat
            end
          end
          if (seg_idx_q == '0) begin
            vlan_d       = pkt_fifo_tdata[C_VLAN_OFFSET +: 12];
            vlan_valid_d = 1'b1;
          end
          if (pkt_fifo_tlast) begin
            seg_idx_d = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (!last_hdr) short_cnt_d = short_cnt_q + 16'd1;
          end else if (last_hdr) begin
            seg_idx_d = '0;
            state_d   = ST_FLUSH;
          end else begin
            seg_idx_d = seg_idx_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (!pkt_fifo_empty && output_fifo_ready) begin
          pkt_fifo_rd_en = 1'b1;
          out_valid_d    = 1'b1;
          out_tdata_d    = pkt_fifo_tdata;
          out_tuser_d    = pkt_fifo_tuser;
          out_tkeep_d    = pkt_fifo_tkeep;
          out_tlast_d    = pkt_fifo_tlast;
          if (pkt_fifo_tlast) begin
            state_d   = ST_HDR;
            seg_idx_d = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d   = ST_HDR;
        seg_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_HDR;
      seg_idx_q    <= '0;
      hdr_tdata_q  <= '0;
      hdr_tuser_q  <= '0;
      hdr_tkeep_q  <= '0;
      hdr_tlast_q  <= '0;
      hdr_valid_q  <= '0;
      vlan_q       <= '0;
      vlan_valid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tuser_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      pkt_cnt_q    <= '0;
      short_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      seg_idx_q    <= seg_idx_d;
      hdr_tdata_q  <= hdr_tdata_d;
      hdr_tuser_q  <= hdr_tuser_d;
      hdr_tkeep_q  <= hdr_tkeep_d;
      hdr_tlast_q  <= hdr_tlast_d;
      hdr_valid_q  <= hdr_valid_d;
      vlan_q       <= vlan_d;
      vlan_valid_q <= vlan_valid_d;
      out_tdata_q  <= out_tdata_d;
      out_tuser_q  <= out_tuser_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_valid_q  <= out_valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
      short_cnt_q  <= short_cnt_d;
    end
  end

  assign hdr_tdata         = hdr_tdata_q;
  assign hdr_tuser         = hdr_tuser_q;
  assign hdr_tkeep         = hdr_tkeep_q;
  assign hdr_tlast         = hdr_tlast_q;
  assign hdr_valid         = hdr_valid_q;
  assign vlan              = vlan_q;
  assign vlan_valid        = vlan_valid_q;
  assign output_fifo_tdata = out_tdata_q;
  assign output_fifo_tuser = out_tuser_q;
  assign output_fifo_tkeep = out_tkeep_q;
  assign output_fifo_tlast = out_tlast_q;
  assign output_fifo_valid = out_valid_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign short_pkt_cnt     = short_cnt_q;

endmodule

// File: tb/tb_depar_seg_splitter.sv
module tb_depar_seg_splitter;

  localparam int W  = 512;
  localparam int U  = 128;
  localparam int KW = W / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- N=2 instance ----------------
  logic [W-1:0] d2_tdata; logic [U-1:0] d2_tuser; logic [KW-1:0] d2_tkeep;
  logic d2_tlast, d2_empty, d2_rd;
  logic [1:0] d2_hrdy, d2_htlast, d2_hvalid;
  logic [2*W-1:0] d2_htdata; logic [2*U-1:0] d2_htuser; logic [2*KW-1:0] d2_htkeep;
  logic [11:0] d2_vlan; logic d2_vv;
  logic [W-1:0] d2_otdata; logic [U-1:0] d2_otuser; logic [KW-1:0] d2_otkeep;
  logic d2_otlast, d2_ovalid, d2_ordy;
  logic [15:0] d2_pkt, d2_short;

  depar_seg_splitter #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U),
                       .C_NUM_HDR_SEGS(2), .C_VLAN_OFFSET(116)) u2 (
    .clk(clk), .aresetn(rst_n),
    .pkt_fifo_tdata(d2_tdata), .pkt_fifo_tuser(d2_tuser), .pkt_fifo_tkeep(d2_tkeep),
    .pkt_fifo_tlast(d2_tlast), .pkt_fifo_empty(d2_empty), .pkt_fifo_rd_en(d2_rd),
    .hdr_fifo_ready(d2_hrdy), .hdr_tdata(d2_htdata), .hdr_tuser(d2_htuser),
    .hdr_tkeep(d2_htkeep), .hdr_tlast(d2_htlast), .hdr_valid(d2_hvalid),
    .vlan(d2_vlan), .vlan_valid(d2_vv),
    .output_fifo_tdata(d2_otdata), .output_fifo_tuser(d2_otuser),
    .output_fifo_tkeep(d2_otkeep), .output_fifo_tlast(d2_otlast),
    .output_fifo_valid(d2_ovalid), .output_fifo_ready(d2_ordy),
    .pkt_cnt(d2_pkt), .short_pkt_cnt(d2_short));

  // ---------------- N=3 instance ----------------
  logic [W-1:0] d3_tdata; logic [U-1:0] d3_tuser; logic [KW-1:0] d3_tkeep;
  logic d3_tlast, d3_empty, d3_rd;
  logic [2:0] d3_hrdy, d3_htlast, d3_hvalid;
  logic [3*W-1:0] d3_htdata; logic [3*U-1:0] d3_htuser; logic [3*KW-1:0] d3_htkeep;
  logic [11:0] d3_vlan; logic d3_vv;
  logic [W-1:0] d3_otdata; logic [U-1:0] d3_otuser; logic [KW-1:0] d3_otkeep;
  logic d3_otlast, d3_ovalid, d3_ordy;
  logic [15:0] d3_pkt, d3_short;

  depar_seg_splitter #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U),
                       .C_NUM_HDR_SEGS(3), .C_VLAN_OFFSET(116)) u3 (
    .clk(clk), .aresetn(rst_n),
    .pkt_fifo_tdata(d3_tdata), .pkt_fifo_tuser(d3_tuser), .pkt_fifo_tkeep(d3_tkeep),
    .pkt_fifo_tlast(d3_tlast), .pkt_fifo_empty(d3_empty), .pkt_fifo_rd_en(d3_rd),
    .hdr_fifo_ready(d3_hrdy), .hdr_tdata(d3_htdata), .hdr_tuser(d3_htuser),
    .hdr_tkeep(d3_htkeep), .hdr_tlast(d3_htlast), .hdr_valid(d3_hvalid),
    .vlan(d3_vlan), .vlan_valid(d3_vv),
    .output_fifo_tdata(d3_otdata), .output_fifo_tuser(d3_otuser),
    .output_fifo_tkeep(d3_otkeep), .output_fifo_tlast(d3_otlast),
    .output_fifo_valid(d3_ovalid), .output_fifo_ready(d3_ordy),
    .pkt_cnt(d3_pkt), .short_pkt_cnt(d3_short));

  // ---------------- N=4 instance ----------------
  logic [W-1:0] d4_tdata; logic [U-1:0] d4_tuser; logic [KW-1:0] d4_tkeep;
  logic d4_tlast, d4_empty, d4_rd;
  logic [3:0] d4_hrdy, d4_htlast, d4_hvalid;
  logic [4*W-1:0] d4_htdata; logic [4*U-1:0] d4_htuser; logic [4*KW-1:0] d4_htkeep;
  logic [11:0] d4_vlan; logic d4_vv;
  logic [W-1:0] d4_otdata; logic [U-1:0] d4_otuser; logic [KW-1:0] d4_otkeep;
  logic d4_otlast, d4_ovalid, d4_ordy;
  logic [15:0] d4_pkt, d4_short;

  depar_seg_splitter #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U),
                       .C_NUM_HDR_SEGS(4), .C_VLAN_OFFSET(116)) u4 (
    .clk(clk), .aresetn(rst_n),
    .pkt_fifo_tdata(d4_tdata), .pkt_fifo_tuser(d4_tuser), .pkt_fifo_tkeep(d4_tkeep),
    .pkt_fifo_tlast(d4_tlast), .pkt_fifo_empty(d4_empty), .pkt_fifo_rd_en(d4_rd),
    .hdr_fifo_ready(d4_hrdy), .hdr_tdata(d4_htdata), .hdr_tuser(d4_htuser),
    .hdr_tkeep(d4_htkeep), .hdr_tlast(d4_htlast), .hdr_valid(d4_hvalid),
    .vlan(d4_vlan), .vlan_valid(d4_vv),
    .output_fifo_tdata(d4_otdata), .output_fifo_tuser(d4_otuser),
    .output_fifo_tkeep(d4_otkeep), .output_fifo_tlast(d4_otlast),
    .output_fifo_valid(d4_ovalid), .output_fifo_ready(d4_ordy),
    .pkt_cnt(d4_pkt), .short_pkt_cnt(d4_short));

  // Segment pattern: seq in [15:0], packet id in [31:16], VLAN at [127:116].
  function automatic logic [W-1:0] mk(input int pk, input int s, input logic [11:0] vl);
    logic [W-1:0] v;
    v = '0;
    v[15:0]    = 16'(s);
    v[31:16]   = 16'(pk);
    v[127:116] = vl;
    v[W-1:W-8] = 8'hA5;
    return v;
  endfunction

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (d2_hvalid !== 2'b00) begin errors++; $display("FAIL rst_hvalid got %b exp 00", d2_hvalid); end
    checks++; if (d2_htdata !== '0) begin errors++; $display("FAIL rst_htdata nonzero"); end
    checks++; if (d2_ovalid !== 1'b0 || d2_otdata !== '0 || d2_otlast !== 1'b0) begin errors++; $display("FAIL rst_out got v=%b l=%b", d2_ovalid, d2_otlast); end
    checks++; if (d2_vlan !== 12'h0 || d2_vv !== 1'b0) begin errors++; $display("FAIL rst_vlan got %h/%b exp 0", d2_vlan, d2_vv); end
    checks++; if (d2_pkt !== 16'd0 || d2_short !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", d2_pkt, d2_short); end
    checks++; if (d2_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %b exp 0", d2_rd); end
  endtask

  task automatic test_n2_four_seg();
    for (int c = 0; c < 4; c++) begin
      d2_empty = 1'b0; d2_tdata = mk(1, c, 12'h123); d2_tlast = (c == 3);
      #2;
      checks++; if (d2_rd !== 1'b1) begin errors++; $display("FAIL n2_rd c%0d got %b exp 1", c, d2_rd); end
      edge_wait();
      case (c)
        0: begin
          checks++; if (d2_hvalid !== 2'b01 || d2_htdata[W-1:0] !== mk(1, 0, 12'h123)) begin errors++; $display("FAIL n2_ch0 hvalid got %b exp 01", d2_hvalid); end
          checks++; if (d2_vlan !== 12'h123 || d2_vv !== 1'b1) begin errors++; $display("FAIL n2_vlan got %h/%b exp 123/1", d2_vlan, d2_vv); end
        end
        1: begin
          checks++; if (d2_hvalid !== 2'b10 || d2_htdata[W +: W] !== mk(1, 1, 12'h123) || d2_htlast !== 2'b00) begin errors++; $display("FAIL n2_ch1 hvalid got %b tlast %b exp 10/00", d2_hvalid, d2_htlast); end
          checks++; if (d2_vv !== 1'b0 || d2_ovalid !== 1'b0) begin errors++; $display("FAIL n2_strobe vv %b ov %b exp 0/0", d2_vv, d2_ovalid); end
        end
        default: begin
          checks++; if (d2_ovalid !== 1'b1 || d2_otdata !== mk(1, c, 12'h123) || d2_otlast !== (c == 3) || d2_hvalid !== 2'b00) begin errors++; $display("FAIL n2_out c%0d got v=%b seq=%0d l=%b hv=%b", c, d2_ovalid, d2_otdata[15:0], d2_otlast, d2_hvalid); end
        end
      endcase
    end
    d2_empty = 1'b1;
    checks++; if (d2_pkt !== 16'd1 || d2_short !== 16'd0) begin errors++; $display("FAIL n2_cnt got %0d/%0d exp 1/0", d2_pkt, d2_short); end
    edge_wait();
    checks++; if (d2_ovalid !== 1'b0) begin errors++; $display("FAIL n2_out_drop got %b exp 0", d2_ovalid); end
  endtask

  task automatic test_n4_short();
    d4_empty = 1'b0; d4_tdata = mk(2, 0, 12'h0AB); d4_tlast = 1'b0;
    #2;
    checks++; if (d4_rd !== 1'b1) begin errors++; $display("FAIL n4_rd0 got %b exp 1", d4_rd); end
    edge_wait();
    checks++; if (d4_hvalid !== 4'b0001 || d4_htdata[W-1:0] !== mk(2, 0, 12'h0AB)) begin errors++; $display("FAIL n4_ch0 hvalid got %b exp 0001", d4_hvalid); end
    d4_tdata = mk(2, 1, 12'h0AB); d4_tlast = 1'b1;
    #2;
    checks++; if (d4_rd !== 1'b1) begin errors++; $display("FAIL n4_rd1 got %b exp 1", d4_rd); end
    edge_wait();
    d4_empty = 1'b1;
    checks++; if (d4_hvalid !== 4'b1110 || d4_htlast !== 4'b0010) begin errors++; $display("FAIL n4_fill hvalid %b tlast %b exp 1110/0010", d4_hvalid, d4_htlast); end
    checks++; if (d4_htdata[W +: W] !== mk(2, 1, 12'h0AB)) begin errors++; $display("FAIL n4_ch1 seq got %0d exp 1", d4_htdata[W +: 16]); end
    checks++; if (d4_htdata[2*W +: 2*W] !== '0 || d4_htuser[2*U +: 2*U] !== '0 || d4_htkeep[2*KW +: 2*KW] !== '0) begin errors++; $display("FAIL n4_filler nonzero"); end
    checks++; if (d4_short !== 16'd1 || d4_pkt !== 16'd1 || d4_ovalid !== 1'b0) begin errors++; $display("FAIL n4_cnt got %0d/%0d ov %b exp 1/1/0", d4_pkt, d4_short, d4_ovalid); end
    #2;
    checks++; if (d4_rd !== 1'b0) begin errors++; $display("FAIL n4_rd_empty got %b exp 0", d4_rd); end
  endtask

  task automatic test_n2_single_ready();
    d2_empty = 1'b0; d2_tdata = mk(3, 0, 12'h5A5); d2_tlast = 1'b1; d2_hrdy = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (d2_rd !== 1'b0) begin errors++; $display("FAIL single_stall_rd c%0d got %b exp 0", c, d2_rd); end
      edge_wait();
      checks++; if (d2_hvalid !== 2'b00 || d2_htdata !== '0) begin errors++; $display("FAIL single_stall_hv c%0d got %b exp 00", c, d2_hvalid); end
    end
    d2_hrdy = 2'b11;
    #2;
    checks++; if (d2_rd !== 1'b1) begin errors++; $display("FAIL single_rd got %b exp 1", d2_rd); end
    edge_wait();
    d2_empty = 1'b1;
    checks++; if (d2_hvalid !== 2'b11 || d2_htlast !== 2'b01) begin errors++; $display("FAIL single_hv got %b tlast %b exp 11/01", d2_hvalid, d2_htlast); end
    checks++; if (d2_htdata[W-1:0] !== mk(3, 0, 12'h5A5) || d2_htdata[W +: W] !== '0) begin errors++; $display("FAIL single_data ch0 seq %0d ch1 nonzero?", d2_htdata[15:0]); end
    checks++; if (d2_pkt !== 16'd2 || d2_short !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d/%0d exp 2/1", d2_pkt, d2_short); end
  endtask

  task automatic test_flush_backpressure();
    int idx, got, popped;
    logic exp_rd;
    idx = 0; got = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      d2_ordy  = !(c >= 3 && c < 8);
      d2_empty = (idx >= 6);
      d2_tdata = mk(4, idx, 12'h777);
      d2_tlast = (idx == 5);
      #2;
      exp_rd = (idx < 6) && (idx < 2 || d2_ordy);
      checks++; if (d2_rd !== exp_rd) begin errors++; $display("FAIL bp_rd c%0d got %b exp %b", c, d2_rd, exp_rd); end
      popped = idx;
      if (exp_rd) idx++;
      edge_wait();
      if (exp_rd && popped >= 2) begin
        checks++; if (d2_ovalid !== 1'b1 || d2_otdata !== mk(4, 2 + got, 12'h777) || d2_otlast !== (popped == 5)) begin errors++; $display("FAIL bp_out c%0d got v=%b seq=%0d exp seq %0d", c, d2_ovalid, d2_otdata[15:0], 2 + got); end
        got++;
      end else begin
        checks++; if (d2_ovalid !== 1'b0) begin errors++; $display("FAIL bp_idle c%0d ovalid got %b exp 0", c, d2_ovalid); end
      end
    end
    d2_empty = 1'b1; d2_ordy = 1'b1;
    checks++; if (got !== 4 || idx !== 6) begin errors++; $display("FAIL bp_count got %0d beats %0d pops exp 4/6", got, idx); end
    checks++; if (d2_pkt !== 16'd3) begin errors++; $display("FAIL bp_pkt got %0d exp 3", d2_pkt); end
  endtask

  task automatic test_back_to_back();
    int lens [3] = '{1, 3, 5};
    int chcnt [3];
    int outcnt, pops;
    chcnt = '{0, 0, 0}; outcnt = 0; pops = 0;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < lens[p]; s++) begin
        d3_empty = 1'b0; d3_tdata = mk(p, s, 12'h300); d3_tlast = (s == lens[p] - 1);
        #2;
        if (d3_rd === 1'b1) pops++;
        edge_wait();
        for (int k = 0; k < 3; k++) if (d3_hvalid[k] === 1'b1) chcnt[k]++;
        if (d3_ovalid === 1'b1) outcnt++;
      end
    end
    d3_empty = 1'b1;
    checks++; if (pops !== 9) begin errors++; $display("FAIL b2b_pops got %0d exp 9", pops); end
    checks++; if (chcnt[0] !== 3 || chcnt[1] !== 3 || chcnt[2] !== 3) begin errors++; $display("FAIL b2b_chan got %0d/%0d/%0d exp 3/3/3", chcnt[0], chcnt[1], chcnt[2]); end
    checks++; if (outcnt !== 2) begin errors++; $display("FAIL b2b_out got %0d exp 2", outcnt); end
    checks++; if (d3_pkt !== 16'd3 || d3_short !== 16'd1) begin errors++; $display("FAIL b2b_cnt got %0d/%0d exp 3/1", d3_pkt, d3_short); end
  endtask

  task automatic test_pkt_wrap();
    d3_empty = 1'b0; d3_tdata = mk(9, 0, 12'h001); d3_tlast = 1'b1;
    repeat (65532) @(posedge clk);
    #1;
    d3_empty = 1'b1;
    checks++; if (d3_pkt !== 16'hFFFF || d3_short !== 16'hFFFD) begin errors++; $display("FAIL wrap_pre got %h/%h exp FFFF/FFFD", d3_pkt, d3_short); end
    d3_empty = 1'b0;
    edge_wait();
    d3_empty = 1'b1;
    checks++; if (d3_pkt !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", d3_pkt); end
  endtask

  task automatic test_reset_in_flush();
    for (int c = 0; c < 3; c++) begin
      d2_empty = 1'b0; d2_tdata = mk(5, c, 12'h456); d2_tlast = 1'b0;
      edge_wait();
    end
    d2_empty = 1'b1;
    checks++; if (d2_ovalid !== 1'b1 || d2_otdata !== mk(5, 2, 12'h456)) begin errors++; $display("FAIL rf_pre ovalid got %b exp 1", d2_ovalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d2_ovalid !== 1'b0 || d2_otdata !== '0 || d2_hvalid !== 2'b00 || d2_htdata !== '0 || d2_vlan !== 12'h0 || d2_pkt !== 16'd0 || d2_short !== 16'd0) begin errors++; $display("FAIL rf_async ov %b hv %b vlan %h pkt %0d", d2_ovalid, d2_hvalid, d2_vlan, d2_pkt); end
    @(posedge clk); #3 rst_n = 1'b1;
    edge_wait();
    d2_empty = 1'b0; d2_tdata = mk(6, 0, 12'h9C3); d2_tlast = 1'b0;
    edge_wait();
    checks++; if (d2_hvalid !== 2'b01 || d2_htdata[W-1:0] !== mk(6, 0, 12'h9C3) || d2_ovalid !== 1'b0 || d2_vlan !== 12'h9C3) begin errors++; $display("FAIL rf_seg0 hv %b ov %b vlan %h exp 01/0/9c3", d2_hvalid, d2_ovalid, d2_vlan); end
    d2_tdata = mk(6, 1, 12'h9C3); d2_tlast = 1'b1;
    edge_wait();
    d2_empty = 1'b1;
    checks++; if (d2_hvalid !== 2'b10 || d2_htlast !== 2'b10 || d2_htdata[W +: W] !== mk(6, 1, 12'h9C3) || d2_ovalid !== 1'b0) begin errors++; $display("FAIL rf_seg1 hv %b tl %b ov %b exp 10/10/0", d2_hvalid, d2_htlast, d2_ovalid); end
    checks++; if (d2_pkt !== 16'd1 || d2_short !== 16'd0) begin errors++; $display("FAIL rf_cnt got %0d/%0d exp 1/0", d2_pkt, d2_short); end
  endtask

  initial begin
    rst_n = 1'b0;
    d2_tdata = '0; d2_tuser = {U{1'b1}}; d2_tkeep = {KW{1'b1}}; d2_tlast = 1'b0; d2_empty = 1'b1; d2_hrdy = 2'b11; d2_ordy = 1'b1;
    d3_tdata = '0; d3_tuser = {U{1'b1}}; d3_tkeep = {KW{1'b1}}; d3_tlast = 1'b0; d3_empty = 1'b1; d3_hrdy = 3'b111; d3_ordy = 1'b1;
    d4_tdata = '0; d4_tuser = {U{1'b1}}; d4_tkeep = {KW{1'b1}}; d4_tlast = 1'b0; d4_empty = 1'b1; d4_hrdy = 4'b1111; d4_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    edge_wait();
    test_n2_four_seg();
    test_n4_short();
    test_n2_single_ready();
    test_flush_backpressure();
    test_back_to_back();
    test_pkt_wrap();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/depar_seg_splitter.md
# depar_seg_splitter

Parametrised segment splitter at the head of the deparser. It pops 512-bit packet segments from the packet FIFO and steers the first C_NUM_HDR_SEGS segments to dedicated per-segment header channels, one beat per channel per packet. It extracts the VLAN ID from segment 0 and streams all remaining segments to the output FIFO. Short packets are padded with zero filler beats so every header channel sees exactly one beat per packet.

## Interface
- C_AXIS_DATA_WIDTH, 512, segment data width
- C_AXIS_TUSER_WIDTH, 128, tuser width
- C_NUM_HDR_SEGS, 2, number of header channels (legal 1..4)
- C_VLAN_OFFSET, 116, LSB of the 12-bit VLAN ID within segment 0 tdata
- clk  in  1  single clock
- aresetn  in  1  asynchronous active-low reset
- pkt_fifo_tdata/tuser/tkeep/tlast  in  W/U/W/8/1  head of packet FIFO (first-word-fall-through)
- pkt_fifo_empty  in  1  packet FIFO empty
- pkt_fifo_rd_en  out  1  combinational pop strobe
- hdr_fifo_ready  in  N  per-channel ready (not-full)
- hdr_tdata  out  N*W  channel k at [k*W +: W]; likewise hdr_tuser (N*U), hdr_tkeep (N*W/8)
- hdr_tlast  out  N  per-channel tlast
- hdr_valid  out  N  per-channel one-cycle write strobe
- vlan  out  12  last captured VLAN ID (holds between packets)
- vlan_valid  out  1  one-cycle strobe, coincident with hdr_valid[0]
- output_fifo_tdata/tuser/tkeep/tlast/valid  out  W/U/W/8/1/1  remaining segments
- output_fifo_ready  in  1  output FIFO not-full
- pkt_cnt  out  16  packets completed, wraps at 0xFFFF→0
- short_pkt_cnt  out  16  packets shorter than N segments, wraps

## Operation
- States: HDR (with seg_idx 0..N-1) and FLUSH. Reset state is HDR with seg_idx=0.
- HDR, seg_idx=k, FIFO non-empty:
  - Non-last segment, k<N-1: requires hdr_fifo_ready[k]. Pop, write channel k with the segment, seg_idx←k+1.
  - Non-last segment, k=N-1: requires hdr_fifo_ready[k]. Pop, write channel k, go to FLUSH.
  - Last segment (tlast=1): requires hdr_fifo_ready[N-1:k] all high.
    - Pop and write channel k with the segment.
    - Write channels k+1..N-1 in the same cycle with filler: tdata/tuser/tkeep=0, tlast=0.
    - seg_idx←0, pkt_cnt+1. If k<N-1, also short_pkt_cnt+1.
  - Required ready missing: no pop, no strobes, state unchanged. Data outputs are don't-care while valid=0 but are driven 0.
- At k=0, on pop: vlan←tdata[C_VLAN_OFFSET+:12] and vlan_valid=1.
- FLUSH, FIFO non-empty, output_fifo_ready=1:
  - Pop and forward the segment to the output FIFO with valid=1.
  - On tlast: go to HDR, seg_idx=0, pkt_cnt+1.
  - If output_fifo_ready=0: stall.
- pkt_fifo_rd_en is never asserted while pkt_fifo_empty=1.
- A 1-segment packet with N=1 is not counted as short.
- FLUSH beats are never written to header channels. Header beats are never written to the output FIFO.

## Timing
- pkt_fifo_rd_en is combinational from state, empty, tlast and readies, in the same cycle as the data it pops.
- All other outputs are registered. Strobes (hdr_valid, vlan_valid, output_fifo_valid) go high the cycle after the pop, for exactly one cycle.
- Throughput is one segment per clock when ready.
- Reset values: all data, valid, tlast outputs, vlan, pkt_cnt and short_pkt_cnt are 0.
- aresetn deasserted mid-packet: state returns to HDR/seg_idx 0 immediately (asynchronous). Upstream must also flush the FIFO; the block does not resynchronise on a partial packet.
- Counters increment on the pop cycle and are visible on the next edge.

## Test plan
- N=2, 4-segment packet, all readies high:
  - pkt_fifo_rd_en high 4 consecutive cycles.
  - hdr_valid=01 then 10.
  - Segments 2–3 on the output FIFO, the second with tlast.
  - vlan=tdata0[127:116] (set to 0x123); pkt_cnt=1.
- N=4, 2-segment packet:
  - Pop 2 only: channel 0, then channels 1–3 together.
  - Channel 1 carries seg 1 with tlast=1; channels 2–3 are zero filler.
  - short_pkt_cnt=1.
- N=2, single-segment packet with hdr_fifo_ready=01:
  - No pop until ready=11.
  - Then hdr_valid=11: channel 1 zero filler, channel 0 tlast=1.
- FLUSH backpressure: output_fifo_ready low for 5 cycles mid-packet.
  - No pops and output valid low during the stall.
  - Resumes with no lost or duplicated segments (check sequence numbers in tdata).
- Back-to-back packets of lengths 1, 3, 5 with N=3:
  - Per-channel beat count equals packets (3 each); pkt_cnt=3; short_pkt_cnt=1.
  - pkt_cnt wraps 0xFFFF→0.
- Assert aresetn low while in FLUSH:
  - Asynchronously all outputs go 0 and state goes to HDR.
  - After release, a fresh 2-segment packet is handled correctly.
